// File: rtl/life_gen_ctrl.sv
// life_gen_ctrl: Game of Life generation sequencer over a toroidal grid.
// Ping-pong banks, one shared single-cell evaluator, row readback.
module life_gen_ctrl #(
  parameter int W  = 8,
  parameter int H  = 8,
  parameter int YW = $clog2(H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [YW-1:0] load_row,
  input  logic [W-1:0]  load_data,
  input  logic          start,
  input  logic [7:0]    gens,
  output logic          busy,
  output logic          done,
  output logic [7:0]    gen_count,
  input  logic [YW-1:0] rd_row,
  output logic [W-1:0]  rd_data,
  output logic          cell_self,
  output logic [7:0]    cell_nbrs,
  input  logic          cell_next
);

  localparam int XW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_SWAP
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [H-1:0][W-1:0] r_bank0;
  logic [H-1:0][W-1:0] r_bank1;
  logic [H-1:0][W-1:0] w_cur;
  logic                r_cur_sel;
  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
  logic [7:0]          r_gens;
  logic [7:0]          r_gen_count;
  logic                r_done;

  logic [XW-1:0] w_xm;
  logic [XW-1:0] w_xp;
  logic [YW-1:0] w_ym;
  logic [YW-1:0] w_yp;
  logic          w_x_last;
  logic          w_y_last;
  logic          w_last_cell;
  logic [7:0]    w_cnt_inc;
  logic          w_run_end;

  assign w_cur       = r_cur_sel ? r_bank1 : r_bank0;
  assign w_x_last    = (r_x == XW'(W-1));
  assign w_y_last    = (r_y == YW'(H-1));
  assign w_last_cell = w_x_last && w_y_last;
  assign w_xm        = (r_x == '0) ? XW'(W-1) : r_x - 1'b1;
  assign w_xp        = w_x_last ? '0 : r_x + 1'b1;
  assign w_ym        = (r_y == '0) ? YW'(H-1) : r_y - 1'b1;
  assign w_yp        = w_y_last ? '0 : r_y + 1'b1;
  assign w_cnt_inc   = r_gen_count + 8'd1;
  assign w_run_end   = (w_cnt_inc == r_gens);

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign gen_count = r_gen_count;
  assign rd_data   = w_cur[rd_row];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next state and evaluator drive; the evaluator only sees cells in EVAL.
  always_comb begin
    w_state_nx = r_state;
    cell_self  = 1'b0;
    cell_nbrs  = 8'd0;
    unique case (r_state)
      S_IDLE: begin
        if (start && gens != 8'd0) w_state_nx = S_EVAL;
      end
      S_EVAL: begin
        cell_self = w_cur[r_y][r_x];
        cell_nbrs = {w_cur[w_yp][w_xp], w_cur[w_yp][r_x],
                     w_cur[w_yp][w_xm], w_cur[r_y][w_xp],
                     w_cur[r_y][w_xm],  w_cur[w_ym][w_xp],
                     w_cur[w_ym][r_x],  w_cur[w_ym][w_xm]};
        if (w_last_cell) w_state_nx = S_SWAP;
      end
      S_SWAP: begin
        w_state_nx = w_run_end ? S_IDLE : S_EVAL;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Grid banks, cell cursor, generation counting and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank0     <= '0;
      r_bank1     <= '0;
      r_cur_sel   <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_gens      <= 8'd0;
      r_gen_count <= 8'd0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_gens      <= gens;
            r_gen_count <= 8'd0;
            r_x         <= '0;
            r_y         <= '0;
            if (gens == 8'd0) r_done <= 1'b1;
          end else if (load_en) begin
            if (r_cur_sel) r_bank1[load_row] <= load_data;
            else           r_bank0[load_row] <= load_data;
          end
        end
        S_EVAL: begin
          if (r_cur_sel) r_bank0[r_y][r_x] <= cell_next;
          else           r_bank1[r_y][r_x] <= cell_next;
          r_x <= w_xp;
          if (w_x_last) r_y <= w_yp;
        end
        S_SWAP: begin
          r_cur_sel   <= ~r_cur_sel;
          r_gen_count <= w_cnt_inc;
          if (w_run_end) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_life_gen_ctrl.sv
// tb_life_gen_ctrl: scoreboard bench for the Life generation sequencer.
// Reference model steps whole grids with modulo-wrapped neighbour sums.
module tb_life_gen_ctrl;

  localparam int W   = 8;
  localparam int H   = 8;
  localparam int YW  = 3;
  localparam int GEN = W * H + 1;

  typedef logic [H-1:0][W-1:0] grid_t;
  typedef struct {
    grid_t rows;
    int    gens;
    int    cyc;
  } item_t;
  typedef struct {
    int         cyc;
    logic       self;
    logic [7:0] nbrs;
  } probe_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en;
  logic [YW-1:0] load_row;
  logic [W-1:0]  load_data;
  logic          start;
  logic [7:0]    gens;
  logic          busy;
  logic          done;
  logic [7:0]    gen_count;
  logic [YW-1:0] rd_row;
  logic [W-1:0]  rd_data;
  logic          cell_self;
  logic [7:0]    cell_nbrs;
  logic          cell_next;

  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  bit     zchk  = 0;
  grid_t  mgrid = '0;
  item_t  sb[$];
  probe_t pq[$];

  life_gen_ctrl #(.W(W), .H(H), .YW(YW)) dut (
    .clk(clk), .rst(rst),
    .load_en(load_en), .load_row(load_row), .load_data(load_data),
    .start(start), .gens(gens),
    .busy(busy), .done(done), .gen_count(gen_count),
    .rd_row(rd_row), .rd_data(rd_data),
    .cell_self(cell_self), .cell_nbrs(cell_nbrs), .cell_next(cell_next)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-cell Life evaluator
  assign cell_next = ($countones(cell_nbrs) == 3) ||
                     (cell_self && $countones(cell_nbrs) == 2);

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", nm, got, want, cyc);
    end
  endtask

  function automatic grid_t step(grid_t g);
    grid_t n;
    int c;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        c = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dx != 0 || dy != 0)
              c += int'(g[(y + dy + H) % H][(x + dx + W) % W]);
        n[y][x] = (c == 3) || (g[y][x] && c == 2);
      end
    return n;
  endfunction

  function automatic logic [7:0] nb(grid_t g, int x, int y);
    int dxs[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int dys[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = g[(y + dys[i] + H) % H][(x + dxs[i] + W) % W];
    return r;
  endfunction

  // Monitor: probes of the evaluator port, done results, zero checks
  initial begin
    item_t  e;
    probe_t p;
    forever begin
      @(negedge clk);
      while (pq.size() != 0 && pq[0].cyc < cyc) begin
        p = pq.pop_front();
        chk("probe_missed", 64'(cyc), 64'(p.cyc));
      end
      while (pq.size() != 0 && pq[0].cyc == cyc) begin
        p = pq.pop_front();
        chk("probe_busy", 64'(busy), 64'd1);
        chk("probe_self", 64'(cell_self), 64'(p.self));
        chk("probe_nbrs", 64'(cell_nbrs), 64'(p.nbrs));
      end
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("done_busy", 64'(busy), 64'd0);
          chk("done_gen_count", 64'(gen_count), 64'(e.gens));
          chk("idle_cell_out", 64'({cell_self, cell_nbrs}), 64'd0);
          for (int r = 0; r < H; r++) begin
            rd_row = YW'(r);
            #1;
            chk($sformatf("row%0d", r), 64'(rd_data), 64'(e.rows[r]));
          end
        end
      end else if (zchk) begin
        zchk = 0;
        chk("zero_busy", 64'(busy), 64'd0);
        chk("zero_gen_count", 64'(gen_count), 64'd0);
        chk("zero_cell_out", 64'({cell_self, cell_nbrs}), 64'd0);
        for (int r = 0; r < H; r++) begin
          rd_row = YW'(r);
          #1;
          chk($sformatf("zero_row%0d", r), 64'(rd_data), 64'd0);
        end
      end
    end
  end

  task automatic load_grid(grid_t g);
    for (int r = 0; r < H; r++) begin
      load_en   = 1'b1;
      load_row  = YW'(r);
      load_data = g[r];
      mgrid[r]  = g[r];
      @(negedge clk);
    end
    load_en = 1'b0;
  endtask

  // Issue a start and push the expected response to the scoreboard.
  task automatic run(int g);
    grid_t  cur;
    item_t  e;
    probe_t p;
    int     k;
    int     idx;
    k   = cyc;
    cur = mgrid;
    for (int gi = 0; gi < g; gi++) begin
      if (gi < 3) begin
        p.cyc  = k + 1 + gi * GEN;
        p.self = cur[0][0];
        p.nbrs = nb(cur, 0, 0);
        pq.push_back(p);
        if (gi == 0) begin
          idx    = $urandom_range(1, W * H - 1);
          p.cyc  = k + 1 + idx;
          p.self = cur[idx / W][idx % W];
          p.nbrs = nb(cur, idx % W, idx / W);
          pq.push_back(p);
        end
      end
      cur = step(cur);
    end
    e.rows = cur;
    e.gens = g;
    e.cyc  = k + 1 + g * GEN;
    sb.push_back(e);
    mgrid = cur;
    start = 1'b1;
    gens  = 8'(g);
    @(negedge clk);
    start = 1'b0;
    gens  = 8'($urandom);
  endtask

  task automatic drain(int lim);
    int i;
    i = 0;
    while ((sb.size() != 0 || pq.size() != 0 || zchk) && i < lim) begin
      @(negedge clk);
      i++;
    end
    if (sb.size() != 0 || pq.size() != 0 || zchk) begin
      chk("drain_timeout", 64'(i), 64'(lim - 1));
      sb.delete();
      pq.delete();
      zchk = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    grid_t g;
    int    n;
    rst = 1'b1; load_en = 1'b0; load_row = '0; load_data = '0;
    start = 1'b0; gens = 8'd0; rd_row = '0;
    repeat (3) @(negedge clk);
    rst  = 1'b0;
    zchk = 1;
    drain(5);

    g = '0; g[3] = 8'b0001_1100;
    load_grid(g);
    run(1); drain(200);
    run(1); drain(200);

    g = '0; g[0] = 8'h02; g[1] = 8'h04; g[2] = 8'h07;
    load_grid(g);
    run(32); drain(2200);

    g = '0; g[7][7] = 1'b1;
    load_grid(g);
    run(1); drain(200);

    g = '0; g[3] = 8'b0001_1000; g[4] = 8'b0001_1000;
    load_grid(g);
    run(10); drain(800);
    run(0); drain(10);

    for (int t = 0; t < 3; t++) begin
      for (int r = 0; r < H; r++) g[r] = 8'($urandom);
      load_grid(g);
      run($urandom_range(1, 4)); drain(400);
    end

    for (int r = 0; r < H; r++) g[r] = 8'($urandom);
    load_grid(g);
    run(3);
    repeat (10) @(negedge clk);
    load_en = 1'b1; load_row = '0; load_data = 8'hFF;
    start = 1'b1; gens = 8'd7;
    repeat (5) @(negedge clk);
    load_en = 1'b0; start = 1'b0;
    drain(300);

    run(1);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", 64'(done), 64'd1);
    run(2); drain(300);

    for (int r = 0; r < H; r++) g[r] = 8'($urandom);
    load_grid(g);
    run(3);
    repeat (99) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    pq.delete();
    mgrid = '0;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    zchk = 1;
    drain(5);
    repeat (3) @(negedge clk);

    g = '0; g[1] = 8'b0000_0111; g[5] = 8'b0110_0000;
    load_grid(g);
    run(2); drain(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
